// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL bit positions, MODE encodings and FSM state encodings.
package timer_counter_pkg;

    localparam logic [3:0] TC_CTRL   = 4'h0;
    localparam logic [3:0] TC_PRESET = 4'h4;
    localparam logic [3:0] TC_COUNT  = 4'h8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Both 1x encodings fall back to one-shot behaviour.
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_AUTO    = 2'b01,
        MODE_RSVD2   = 2'b10,
        MODE_RSVD3   = 2'b11
    } tc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of the timer: byte address, qualified write strobe,
// write data, combinational read data and the interrupt request.
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, we, din, input dout, irq);
    modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// maskable interrupt. CTRL +0x0, PRESET +0x4, COUNT +0x8 (read-only).
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | waiting for CTRL.EN
//  ST_LOAD | COUNT <= PRESET
//  ST_CNT  | decrementing COUNT; EN=0 aborts back to IDLE with COUNT held
//  ST_INT  | expiry; one-shot clears EN, auto-reload keeps EN and drops the flag
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    localparam logic [1:0] IDX_CTRL   = TC_CTRL[3:2];
    localparam logic [1:0] IDX_PRESET = TC_PRESET[3:2];
    localparam logic [1:0] IDX_COUNT  = TC_COUNT[3:2];

    tc_state_e   state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        int_flag_q, int_flag_d;

    logic        sel;
    logic        wr;
    logic [1:0]  idx;
    tc_mode_e    mode;
    logic        unused_addr_bits;

    assign sel  = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr   = bus.we & sel;
    assign idx  = bus.addr[3:2];
    assign mode = tc_mode_e'(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);
    assign unused_addr_bits = ^bus.addr[1:0];

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        int_flag_d = int_flag_q;

        // Bus clear comes first so that a flag set on the expiry edge overrides it.
        if (wr && (idx == IDX_CTRL || idx == IDX_PRESET)) begin
            int_flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    int_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                state_d = ST_IDLE;
                if (mode == MODE_AUTO) begin
                    int_flag_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A CTRL write lands after the FSM so it overrides the one-shot EN clear.
        if (wr && idx == IDX_CTRL) begin
            ctrl_d = bus.din[3:0];
        end
        if (wr && idx == IDX_PRESET) begin
            preset_d = bus.din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            int_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            int_flag_q <= int_flag_d;
        end
    end

    always_comb begin
        case (idx)
            IDX_CTRL:   bus.dout = {28'd0, ctrl_q};
            IDX_PRESET: bus.dout = preset_q;
            IDX_COUNT:  bus.dout = count_q;
            default:    bus.dout = 32'd0;
        endcase
    end

    assign bus.irq = int_flag_q & ctrl_q[CTRL_IM];

endmodule
